// File: rtl/wb_stage_ctl_pkg.sv
// Shared types for the writeback stage: writeback source, access size and
// the W-stage state encoding.
package wb_pkg;

  typedef enum logic [1:0] {
    WD_ALU  = 2'd0,
    WD_MEM  = 2'd1,
    WD_LINK = 2'd2,
    WD_CP0  = 2'd3
  } wd_sel_e;

  typedef enum logic [1:0] {
    MT_BYTE  = 2'd0,
    MT_HALF  = 2'd1,
    MT_WORD  = 2'd2,
    MT_DWORD = 2'd3
  } mem_type_e;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    WAIT_MEM = 2'd1,
    COMMIT   = 2'd2
  } wb_state_e;

endpackage

// File: rtl/wb_stage_ctl_if.sv
// Bundle of every M-stage, data-memory, register-file and forwarding signal
// the writeback stage talks to. The master side is the surrounding pipeline,
// the slave side is the W stage itself.
interface wb_stage_ctl_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int PC_W   = 32
);
  import wb_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [PC_W-1:0]   in_pc;
  wd_sel_e           in_wd_sel;
  logic              in_rf_we;
  logic [REG_AW-1:0] in_rf_addr;
  logic [DATA_W-1:0] in_alu;
  logic [DATA_W-1:0] in_cp0;
  mem_type_e         in_mem_type;
  logic              in_load_signed;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;
  logic              flush;
  logic              rf_we;
  logic [REG_AW-1:0] rf_addr;
  logic [DATA_W-1:0] rf_wdata;
  logic              fwd_valid;
  logic [REG_AW-1:0] fwd_addr;
  logic [DATA_W-1:0] fwd_data;
  logic              fwd_pending;
  logic              spurious_rvalid;

  modport master (
    output in_valid, in_pc, in_wd_sel, in_rf_we, in_rf_addr, in_alu, in_cp0,
           in_mem_type, in_load_signed, mem_rvalid, mem_rdata, flush,
    input  in_ready, rf_we, rf_addr, rf_wdata, fwd_valid, fwd_addr, fwd_data,
           fwd_pending, spurious_rvalid
  );

  modport slave (
    input  in_valid, in_pc, in_wd_sel, in_rf_we, in_rf_addr, in_alu, in_cp0,
           in_mem_type, in_load_signed, mem_rvalid, mem_rdata, flush,
    output in_ready, rf_we, rf_addr, rf_wdata, fwd_valid, fwd_addr, fwd_data,
           fwd_pending, spurious_rvalid
  );

endinterface

// File: rtl/wb_stage_ctl_load_align.sv
// Load data aligner: picks the addressed lane out of a memory line and
// sign- or zero-extends it to the datapath width. Dword on a 32-bit
// datapath degrades to a word access.
module load_align
  import wb_pkg::*;
#(
  parameter  int DATA_W = 32,
  localparam int OFF_W  = $clog2(DATA_W / 8)
) (
  input  logic [DATA_W-1:0] rdata_i,
  input  logic [OFF_W-1:0]  offset_i,
  input  mem_type_e         type_i,
  input  logic              signed_i,
  output logic [DATA_W-1:0] value_o
);

  logic [OFF_W-1:0]  base;
  logic [DATA_W-1:0] raw;
  logic              fill;
  int                nbits;

  // Shift the naturally aligned lane down to bit 0, then extend above its width
  always_comb begin
    base  = offset_i;
    nbits = DATA_W;
    case (type_i)
      MT_BYTE: begin
        nbits = 8;
      end
      MT_HALF: begin
        nbits = 16;
        base  = offset_i & ~OFF_W'(1);
      end
      MT_WORD: begin
        nbits = 32;
        base  = offset_i & ~OFF_W'(3);
      end
      default: begin
        if (DATA_W == 64) begin
          nbits = 64;
          base  = '0;
        end else begin
          nbits = 32;
          base  = offset_i & ~OFF_W'(3);
        end
      end
    endcase
    raw = rdata_i >> {base, 3'b000};
    case (type_i)
      MT_BYTE: fill = signed_i & raw[7];
      MT_HALF: fill = signed_i & raw[15];
      MT_WORD: fill = signed_i & raw[31];
      default: fill = signed_i & raw[DATA_W-1];
    endcase
    value_o = '0;
    for (int i = 0; i < DATA_W; i++) begin
      value_o[i] = (i < nbits) ? raw[i] : fill;
    end
  end

endmodule

// File: rtl/wb_stage_ctl.sv
// Writeback stage with its own M/W register. Non-loads commit the cycle
// after they are accepted; loads park in WAIT_MEM until the data memory
// answers. The register-file port and bypass outputs come only from
// registered state.
module wb_stage_ctl
  import wb_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int REG_AW      = 5,
  parameter int PC_W        = 32,
  parameter int LINK_OFFSET = 8
) (
  input logic           clk,
  input logic           reset,
  wb_stage_ctl_if.slave bus
);

  localparam int OFF_W = $clog2(DATA_W / 8);

  if (!((DATA_W == 32) || (DATA_W == 64)) || (PC_W > DATA_W)) begin : g_bad_params
    $error("wb_stage_ctl: DATA_W must be 32 or 64 and PC_W must not exceed DATA_W");
  end

  wb_state_e         state_q, state_d;
  logic              we_q, we_d;
  logic [REG_AW-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [OFF_W-1:0]  off_q, off_d;
  mem_type_e         type_q, type_d;
  logic              sgn_q, sgn_d;
  logic              discard_q, discard_d;
  logic              spur_q, spur_d;

  logic              accept;
  logic              writes_reg;
  logic [DATA_W-1:0] aligned;
  logic [DATA_W-1:0] accept_value;

  load_align #(.DATA_W(DATA_W)) u_align (
    .rdata_i  (bus.mem_rdata),
    .offset_i (off_q),
    .type_i   (type_q),
    .signed_i (sgn_q),
    .value_o  (aligned)
  );

  assign accept     = bus.in_valid && (state_q != WAIT_MEM);
  assign writes_reg = we_q && (addr_q != '0);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= EMPTY;
    else       state_q <= state_d;
  end

  // Next state: flush wins over both a pending response and a new accept
  always_comb begin
    state_d = state_q;
    if (bus.flush) begin
      state_d = EMPTY;
    end else if (state_q == WAIT_MEM) begin
      if (bus.mem_rvalid) state_d = COMMIT;
    end else if (accept) begin
      state_d = (bus.in_wd_sel == WD_MEM) ? WAIT_MEM : COMMIT;
    end else begin
      state_d = EMPTY;
    end
  end

  // Held instruction and flag updates; a response that lands in the same
  // cycle as the flush has already been consumed, so it arms no discard
  always_comb begin
    we_d      = we_q;
    addr_d    = addr_q;
    data_d    = data_q;
    off_d     = off_q;
    type_d    = type_q;
    sgn_d     = sgn_q;
    discard_d = discard_q;
    spur_d    = spur_q;
    case (bus.in_wd_sel)
      WD_LINK: accept_value = DATA_W'(bus.in_pc) + DATA_W'(LINK_OFFSET);
      WD_CP0:  accept_value = bus.in_cp0;
      default: accept_value = bus.in_alu;
    endcase
    if (bus.mem_rvalid && (state_q != WAIT_MEM)) begin
      if (discard_q) discard_d = 1'b0;
      else           spur_d    = 1'b1;
    end
    if (bus.flush) begin
      if ((state_q == WAIT_MEM) && !bus.mem_rvalid) discard_d = 1'b1;
    end else if (state_q == WAIT_MEM) begin
      if (bus.mem_rvalid) data_d = aligned;
    end else if (accept) begin
      we_d   = bus.in_rf_we;
      addr_d = bus.in_rf_addr;
      off_d  = bus.in_alu[OFF_W-1:0];
      type_d = bus.in_mem_type;
      sgn_d  = bus.in_load_signed;
      if (bus.in_wd_sel != WD_MEM) data_d = accept_value;
    end
  end

  // Held instruction registers
  always_ff @(posedge clk) begin
    if (reset) begin
      we_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      off_q     <= '0;
      type_q    <= MT_BYTE;
      sgn_q     <= 1'b0;
      discard_q <= 1'b0;
      spur_q    <= 1'b0;
    end else begin
      we_q      <= we_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      off_q     <= off_d;
      type_q    <= type_d;
      sgn_q     <= sgn_d;
      discard_q <= discard_d;
      spur_q    <= spur_d;
    end
  end

  // Outputs decoded from the state and held registers only
  always_comb begin
    bus.in_ready        = (state_q != WAIT_MEM);
    bus.rf_we           = (state_q == COMMIT) && writes_reg;
    bus.rf_addr         = addr_q;
    bus.rf_wdata        = data_q;
    bus.fwd_valid       = (state_q == COMMIT) && writes_reg;
    bus.fwd_addr        = addr_q;
    bus.fwd_data        = data_q;
    bus.fwd_pending     = (state_q == WAIT_MEM) && writes_reg;
    bus.spurious_rvalid = spur_q;
  end

endmodule

// File: tb/tb_wb_stage_ctl.sv
// Bench for wb_stage_ctl: a 32-bit and a 64-bit instance receive the same
// directed stimulus; a transaction-level model predicts every output and a
// handful of literal expectations pin the model.
module tb_wb_stage_ctl;
  import wb_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  wb_stage_ctl_if #(.DATA_W(32), .REG_AW(5), .PC_W(32)) if32 ();
  wb_stage_ctl_if #(.DATA_W(64), .REG_AW(5), .PC_W(32)) if64 ();

  wb_stage_ctl #(.DATA_W(32), .REG_AW(5), .PC_W(32), .LINK_OFFSET(8)) dut32 (
    .clk   (clk),
    .reset (reset),
    .bus   (if32)
  );

  wb_stage_ctl #(.DATA_W(64), .REG_AW(5), .PC_W(32), .LINK_OFFSET(8)) dut64 (
    .clk   (clk),
    .reset (reset),
    .bus   (if64)
  );

  // Stimulus shared by both instances (the 32-bit one sees the low half)
  logic        sValid = 0, sWe = 0, sSgn = 0, sRvalid = 0, sFlush = 0;
  wd_sel_e     sSel = WD_ALU;
  mem_type_e   sType = MT_BYTE;
  logic [4:0]  sAddr = 0;
  logic [31:0] sPc = 0;
  logic [63:0] sAlu = 0, sCp0 = 0, sRdata = 0;

  // Model state per instance: index 0 is the 32-bit DUT, 1 the 64-bit one
  bit          mLoad[2], mCommit[2], mWe[2], mSgn[2], mDiscard[2], mSpur[2];
  logic [4:0]  mAddr[2];
  logic [63:0] mData[2], mAlu[2];
  int          mType[2];
  bit          modelLive = 0;

  function automatic logic [63:0] maskTo(int w, logic [63:0] v);
    return (w == 32) ? {32'h0, v[31:0]} : v;
  endfunction

  function automatic logic [63:0] alignModel(int w, logic [63:0] rdata, logic [63:0] alu,
                                             int mtype, bit sgn);
    int bytes = w / 8;
    int off = int'(alu % 64'(bytes));
    int size = (mtype == 3) ? ((w == 64) ? 8 : 4) : (1 << mtype);
    int base = off - (off % size);
    logic [63:0] v = maskTo(w, rdata) >> (8 * base);
    if (size < 8) begin
      v = v & ((64'd1 << (8 * size)) - 64'd1);
      if (sgn && (size * 8 < w) && v[8 * size - 1]) v = v - (64'd1 << (8 * size));
    end
    return maskTo(w, v);
  endfunction

  task automatic modelStep(int w);
    if (reset) begin
      mLoad[w] = 0; mCommit[w] = 0; mWe[w] = 0; mSgn[w] = 0; mDiscard[w] = 0;
      mSpur[w] = 0; mAddr[w] = 0; mData[w] = 0; mAlu[w] = 0; mType[w] = 0;
      return;
    end
    if (sRvalid && !mLoad[w]) begin
      if (mDiscard[w]) mDiscard[w] = 0;
      else mSpur[w] = 1;
    end
    if (sFlush) begin
      if (mLoad[w] && !sRvalid) mDiscard[w] = 1;
      mLoad[w] = 0;
      mCommit[w] = 0;
    end else if (mLoad[w]) begin
      if (sRvalid) begin
        mData[w] = alignModel(w == 0 ? 32 : 64, sRdata, mAlu[w], mType[w], mSgn[w]);
        mLoad[w] = 0;
        mCommit[w] = 1;
      end
    end else if (sValid) begin
      mWe[w] = sWe; mAddr[w] = sAddr; mAlu[w] = sAlu; mType[w] = int'(sType); mSgn[w] = sSgn;
      mLoad[w] = (sSel == WD_MEM);
      mCommit[w] = (sSel != WD_MEM);
      case (sSel)
        WD_ALU:  mData[w] = maskTo(w == 0 ? 32 : 64, sAlu);
        WD_LINK: mData[w] = maskTo(w == 0 ? 32 : 64, {32'h0, sPc} + 64'd8);
        WD_CP0:  mData[w] = maskTo(w == 0 ? 32 : 64, sCp0);
        default: ;
      endcase
    end else begin
      mCommit[w] = 0;
    end
  endtask

  // Advance the model on every clock edge from the stimulus in force
  always @(posedge clk) begin
    for (int w = 0; w < 2; w++) modelStep(w);
    if (reset) modelLive = 1;
  end

  task automatic checkOutput(string name, logic [63:0] actual, logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%h, wanted 0x%h at %0t", name, actual, expected, $time);
    end
  endtask

  // Compare both instances against the model on every falling edge
  always @(negedge clk) begin
    if (modelLive) begin
      for (int w = 0; w < 2; w++) begin
        logic [63:0] aData, aFwd;
        logic [4:0]  aAddr, aFwdAddr;
        logic        aRdy, aWe, aFv, aPend, aSpur;
        bit          eWe;
        if (w == 0) begin
          aRdy = if32.in_ready; aWe = if32.rf_we; aAddr = if32.rf_addr;
          aData = {32'h0, if32.rf_wdata}; aFv = if32.fwd_valid; aFwdAddr = if32.fwd_addr;
          aFwd = {32'h0, if32.fwd_data}; aPend = if32.fwd_pending; aSpur = if32.spurious_rvalid;
        end else begin
          aRdy = if64.in_ready; aWe = if64.rf_we; aAddr = if64.rf_addr;
          aData = if64.rf_wdata; aFv = if64.fwd_valid; aFwdAddr = if64.fwd_addr;
          aFwd = if64.fwd_data; aPend = if64.fwd_pending; aSpur = if64.spurious_rvalid;
        end
        eWe = mCommit[w] && mWe[w] && (mAddr[w] != 0);
        checkOutput($sformatf("model w%0d in_ready", w), 64'(aRdy), 64'(!mLoad[w]));
        checkOutput($sformatf("model w%0d rf_we", w), 64'(aWe), 64'(eWe));
        checkOutput($sformatf("model w%0d rf_addr", w), 64'(aAddr), 64'(mAddr[w]));
        checkOutput($sformatf("model w%0d rf_wdata", w), aData, mData[w]);
        checkOutput($sformatf("model w%0d fwd_valid", w), 64'(aFv), 64'(eWe));
        checkOutput($sformatf("model w%0d fwd_addr", w), 64'(aFwdAddr), 64'(mAddr[w]));
        checkOutput($sformatf("model w%0d fwd_data", w), aFwd, mData[w]);
        checkOutput($sformatf("model w%0d fwd_pending", w), 64'(aPend),
                    64'(mLoad[w] && mWe[w] && (mAddr[w] != 0)));
        checkOutput($sformatf("model w%0d spurious", w), 64'(aSpur), 64'(mSpur[w]));
      end
    end
  end

  task automatic pushInputs();
    if32.in_valid = sValid;         if64.in_valid = sValid;
    if32.in_pc = sPc;               if64.in_pc = sPc;
    if32.in_wd_sel = sSel;          if64.in_wd_sel = sSel;
    if32.in_rf_we = sWe;            if64.in_rf_we = sWe;
    if32.in_rf_addr = sAddr;        if64.in_rf_addr = sAddr;
    if32.in_alu = sAlu[31:0];       if64.in_alu = sAlu;
    if32.in_cp0 = sCp0[31:0];       if64.in_cp0 = sCp0;
    if32.in_mem_type = sType;       if64.in_mem_type = sType;
    if32.in_load_signed = sSgn;     if64.in_load_signed = sSgn;
    if32.mem_rvalid = sRvalid;      if64.mem_rvalid = sRvalid;
    if32.mem_rdata = sRdata[31:0];  if64.mem_rdata = sRdata;
    if32.flush = sFlush;            if64.flush = sFlush;
  endtask

  task automatic applyStimulus(logic valid, wd_sel_e sel, logic we, logic [4:0] addr,
                               logic [63:0] alu, logic [31:0] pc, logic [63:0] cp0,
                               mem_type_e mtype, logic sgn);
    sValid = valid; sSel = sel; sWe = we; sAddr = addr; sAlu = alu;
    sPc = pc; sCp0 = cp0; sType = mtype; sSgn = sgn;
    pushInputs();
  endtask

  task automatic idle();
    applyStimulus(0, WD_ALU, 0, 0, 0, 0, 0, MT_BYTE, 0);
  endtask

  task automatic setMem(logic rvalid, logic [63:0] rdata);
    sRvalid = rvalid; sRdata = rdata;
    pushInputs();
  endtask

  task automatic setFlush(logic f);
    sFlush = f;
    pushInputs();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Run a one-cycle-latency load on both instances and check the literal results
  task automatic loadOnce(string name, logic [63:0] alu, mem_type_e mtype, logic sgn,
                          logic [63:0] rdata, logic [63:0] exp32, logic [63:0] exp64);
    applyStimulus(1, WD_MEM, 1, 5, alu, 0, 0, mtype, sgn);
    step();
    idle();
    setMem(1, rdata);
    step();
    setMem(0, 0);
    checkOutput({name, " we"}, 64'(if32.rf_we), 64'd1);
    checkOutput({name, " w32"}, {32'h0, if32.rf_wdata}, exp32);
    checkOutput({name, " w64"}, if64.rf_wdata, exp64);
  endtask

  initial begin
    idle();
    setMem(0, 0);
    setFlush(0);
    repeat (2) step();
    checkOutput("reset in_ready", 64'(if32.in_ready), 64'd1);
    checkOutput("reset rf_we", 64'(if32.rf_we), 64'd0);
    checkOutput("reset rf_wdata", {32'h0, if32.rf_wdata}, 64'd0);
    checkOutput("reset spurious", 64'(if64.spurious_rvalid), 64'd0);
    reset = 1'b0;

    // Back-to-back ALU results, the last one targeting $0
    applyStimulus(1, WD_ALU, 1, 3, 64'h11, 0, 0, MT_WORD, 0);
    step();
    checkOutput("alu1 we", 64'(if32.rf_we), 64'd1);
    checkOutput("alu1 addr", 64'(if32.rf_addr), 64'd3);
    checkOutput("alu1 data", {32'h0, if32.rf_wdata}, 64'h11);
    applyStimulus(1, WD_ALU, 1, 4, 64'h22, 0, 0, MT_WORD, 0);
    checkOutput("alu ready", 64'(if32.in_ready), 64'd1);
    step();
    checkOutput("alu2 we", 64'(if32.rf_we), 64'd1);
    checkOutput("alu2 data", {32'h0, if32.rf_wdata}, 64'h22);
    applyStimulus(1, WD_ALU, 1, 0, 64'h33, 0, 0, MT_WORD, 0);
    step();
    checkOutput("alu3 r0 no write", 64'(if32.rf_we), 64'd0);
    checkOutput("alu3 ready", 64'(if32.in_ready), 64'd1);
    idle();
    step();

    // CP0 source
    applyStimulus(1, WD_CP0, 1, 12, 64'h55, 0, 64'hCAFE0001, MT_WORD, 0);
    step();
    idle();
    checkOutput("cp0 data", {32'h0, if32.rf_wdata}, 64'hCAFE0001);
    step();

    // Byte and half loads with lane selection and extension
    loadOnce("lb off3", 64'd3, MT_BYTE, 1, 64'h80FF7F01, 64'hFFFFFF80, 64'hFFFFFFFFFFFFFF80);
    loadOnce("lbu off2", 64'd2, MT_BYTE, 0, 64'h80FF7F01, 64'h000000FF, 64'h00000000000000FF);
    loadOnce("lh off3", 64'd3, MT_HALF, 1, 64'h80FF7F01, 64'hFFFF80FF, 64'hFFFFFFFFFFFF80FF);
    loadOnce("lh off1", 64'd1, MT_HALF, 1, 64'h80FF7F01, 64'h00007F01, 64'h0000000000007F01);
    idle();
    step();

    // Word load whose response arrives four cycles after accept
    applyStimulus(1, WD_MEM, 1, 7, 64'd0, 0, 0, MT_WORD, 0);
    step();
    idle();
    for (int k = 1; k <= 4; k++) begin
      if (k == 4) setMem(1, 64'hDEADBEEF);
      checkOutput($sformatf("lat4 ready c%0d", k), 64'(if32.in_ready), 64'd0);
      checkOutput($sformatf("lat4 pending c%0d", k), 64'(if32.fwd_pending), 64'd1);
      step();
    end
    setMem(0, 0);
    checkOutput("lat4 we", 64'(if32.rf_we), 64'd1);
    checkOutput("lat4 data", {32'h0, if32.rf_wdata}, 64'hDEADBEEF);

    // Link write
    applyStimulus(1, WD_LINK, 1, 31, 64'h0, 32'h00003000, 0, MT_WORD, 0);
    step();
    idle();
    checkOutput("link addr", 64'(if32.rf_addr), 64'd31);
    checkOutput("link data", {32'h0, if32.rf_wdata}, 64'h00003008);
    step();

    // Flush while committing: the write completes, the new accept is dropped
    applyStimulus(1, WD_ALU, 1, 7, 64'h77, 0, 0, MT_WORD, 0);
    step();
    applyStimulus(1, WD_ALU, 1, 8, 64'h88, 0, 0, MT_WORD, 0);
    setFlush(1);
    checkOutput("flush commit we", 64'(if32.rf_we), 64'd1);
    step();
    setFlush(0);
    idle();
    checkOutput("flush drops accept", 64'(if32.rf_we), 64'd0);
    step();

    // Flush while waiting, then a late response and an unsolicited one
    applyStimulus(1, WD_MEM, 1, 6, 64'd0, 0, 0, MT_WORD, 0);
    step();
    idle();
    setFlush(1);
    step();
    setFlush(0);
    checkOutput("flush wait ready", 64'(if32.in_ready), 64'd1);
    checkOutput("flush wait no we", 64'(if32.rf_we), 64'd0);
    setMem(1, 64'h1234);
    step();
    setMem(0, 0);
    checkOutput("late rvalid no we", 64'(if32.rf_we), 64'd0);
    checkOutput("late rvalid not spurious", 64'(if32.spurious_rvalid), 64'd0);
    step();
    setMem(1, 64'h5678);
    step();
    setMem(0, 0);
    checkOutput("unsolicited spurious", 64'(if32.spurious_rvalid), 64'd1);
    step();
    checkOutput("spurious sticky", 64'(if64.spurious_rvalid), 64'd1);

    // Reset clears the sticky flag
    reset = 1'b1;
    step();
    reset = 1'b0;
    checkOutput("reset clears spurious", 64'(if32.spurious_rvalid), 64'd0);

    // Dword, and a signed half in the top lane of a 64-bit line
    loadOnce("ld dword", 64'd0, MT_DWORD, 0, 64'h8000000000000001, 64'h00000001,
             64'h8000000000000001);
    loadOnce("lh off6", 64'd6, MT_HALF, 1, 64'h8000000000000001, 64'h00000000,
             64'hFFFFFFFFFFFF8000);
    idle();
    repeat (2) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_stage_ctl.md
# wb_stage_ctl

Parametrised writeback stage of the five-stage pipeline, with its own M/W pipeline register. It accepts one retiring instruction per cycle from the memory stage. Loads wait in a small state machine until a variable-latency data-memory response arrives, and load data is aligned and extended for byte, half, word or dword accesses. The block drives the register-file write port and the W-stage forwarding and hazard signals.

## Interface
Parameters:
- DATA_W, 32, datapath width; legal values are 32 or 64.
- REG_AW, 5, register-file address width.
- PC_W, 32, program-counter width; PC_W <= DATA_W.
- LINK_OFFSET, 8, constant added to the PC for link writes.

Ports:
- clk  in  1  stage clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  M stage presents an instruction.
- in_ready  out  1  W stage can accept this cycle.
- in_pc  in  PC_W  instruction PC.
- in_wd_sel  in  2  writeback source: 0 ALU, 1 MEM, 2 LINK, 3 CP0.
- in_rf_we  in  1  instruction writes the register file.
- in_rf_addr  in  REG_AW  destination register.
- in_alu  in  DATA_W  ALU result; the low bits give the load byte offset.
- in_cp0  in  DATA_W  CP0 read data.
- in_mem_type  in  2  access size: 0 byte, 1 half, 2 word, 3 dword.
- in_load_signed  in  1  1 = sign-extend, 0 = zero-extend.
- mem_rvalid  in  1  data-memory response valid.
- mem_rdata  in  DATA_W  aligned memory line.
- flush  in  1  exception or redirect kill.
- rf_we / rf_addr / rf_wdata  out  1 / REG_AW / DATA_W  register-file write port.
- fwd_valid  out  1  fwd_addr/fwd_data carry a usable bypass value.
- fwd_addr / fwd_data  out  REG_AW / DATA_W  bypass destination and value.
- fwd_pending  out  1  a load in W has not yet returned; the hazard unit must stall any dependent consumer.
- spurious_rvalid  out  1  sticky flag; set when mem_rvalid arrives while the state is not WAIT_MEM.

## Operation
States:
- EMPTY: no instruction held.
- WAIT_MEM: a load is held and its response is outstanding.
- COMMIT: the writeback value is held and is being written.

Accept and transitions:
- Accept occurs when in_valid & in_ready.
- in_ready = (state != WAIT_MEM).
- Accepted instruction with in_wd_sel=MEM goes to WAIT_MEM.
- Any other accepted instruction goes to COMMIT.
- COMMIT with no accept goes to EMPTY.
- WAIT_MEM & mem_rvalid: the aligned data is captured and the state goes to COMMIT.

Writeback value, latched at accept except for MEM:
- ALU: in_alu.
- LINK: zero_extend(in_pc) + LINK_OFFSET, computed modulo 2^DATA_W.
- CP0: in_cp0.
- MEM: load_align(mem_rdata, in_alu offset, type, signed), computed when mem_rvalid is seen.

Load alignment:
- Offset is in_alu[log2(DATA_W/8)-1:0].
- Byte: lane selected by the full offset.
- Half: offset with bit 0 ignored.
- Word: offset with bits [1:0] ignored.
- Dword: valid only when DATA_W=64; with DATA_W=32 it is treated as word.
- Misaligned addresses are not trapped here; address checks belong to the M stage.

Register-file write:
- In COMMIT: rf_we = held we & (held addr != 0).
- rf_addr and rf_wdata come from the held registers.

Forwarding:
- fwd_valid = rf_we, with fwd_addr/fwd_data equal to rf_addr/rf_wdata.
- fwd_pending = (state == WAIT_MEM) & held we & (held addr != 0).

Flush:
- In WAIT_MEM: the state goes to EMPTY with no write, and the outstanding response is discarded. The first mem_rvalid that follows is not flagged spurious; a one-deep discard bit is set for it.
- A same-cycle accept is dropped.
- COMMIT still completes its write, because that instruction is already architecturally retired.

## Timing
- Reset: state EMPTY, in_ready=1, rf_we=0, rf_addr=0, rf_wdata=0, fwd_valid=0, fwd_pending=0, spurious_rvalid=0, discard bit 0.
- Non-load: accepted at edge T; rf_we is high during cycle T+1. Throughput is 1 per cycle, since a COMMIT may accept the next instruction in the same cycle.
- Load: accepted at edge T. mem_rvalid is legal from cycle T+1 onward; mem_rvalid already high at cycle T+1 gives 1 wait cycle. If mem_rvalid is first high in cycle T+k, rf_we is high during cycle T+k+1.
- rf_* and fwd_* are driven only from registers; there is no combinational path from in_* to rf_*.
- reset asserted in any state returns the block to its reset values at the next edge.
- reset has priority over flush, and flush has priority over accept and mem_rvalid.

## Structure
- Shared package wb_pkg holds:
  - enum wd_sel_e {WD_ALU, WD_MEM, WD_LINK, WD_CP0};
  - enum mem_type_e {MT_BYTE, MT_HALF, MT_WORD, MT_DWORD};
  - enum wb_state_e {EMPTY, WAIT_MEM, COMMIT}.
- Sub-module load_align: combinational, parametrised on DATA_W. Inputs are rdata, offset, type and signed; output is the extended value.
- Parameter legality is checked with an elaboration-time assertion.

## Test plan
- ALU back-to-back: three instructions on consecutive cycles, writing $3=0x11, $4=0x22 and $0=0x33. Expect rf_we pulses on cycles T+1 and T+2 carrying the correct data, no write on T+3, and in_ready constantly 1.
- Load byte, signed, DATA_W=32: mem_rdata=0x80FF7F01 with offset 3. Expect 0xFFFFFF80. With offset 2 and unsigned, expect 0x000000FF.
- Load latency 4: mem_rvalid is first high on cycle T+4. Expect in_ready=0 and fwd_pending=1 during T+1..T+4, and rf_we on T+5.
- Link: in_pc=0x00003000 with wd_sel=LINK writing $31. Expect rf_wdata=0x00003008.
- Flush during WAIT_MEM, followed by a late mem_rvalid. Expect no write and spurious_rvalid=0. A second unsolicited mem_rvalid afterwards sets spurious_rvalid=1.
- DATA_W=64 dword: mem_rdata=0x8000000000000001 with MT_DWORD. Expect the full value. The same data with a signed half at offset 6 gives 0xFFFFFFFFFFFF8000.
